// File: rtl/uart_mem_bridge.sv
// Byte-addressed memory slave driven by a framed UART byte stream.
// Serves framed reads/writes from an internal RAM, or forwards them to an MMIO side-port inside the I/O window.
module uart_mem_bridge #(
    parameter int          MEM_AW  = 12,
    parameter logic [31:0] IO_BASE = 32'h100,
    parameter int          IO_AW   = 4,
    parameter int          ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             io_req,
    output logic             io_we,
    output logic [IO_AW-1:0] io_addr,
    output logic [7:0]       io_wdata,
    input  logic [7:0]       io_rdata,
    input  logic             io_ack,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_WCOMMIT = 3'd3,
        S_RFETCH  = 3'd4,
        S_RSEND   = 3'd5
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) return v;
        else return v + {{(ERR_W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r, state_n;
    logic             is_read_r;
    logic [1:0]       len_r;
    logic [2:0]       cnt_r;
    logic [1:0]       idx_r;
    logic [31:0]      addr_r;
    logic [31:0]      data_r;
    logic             rx_ready_r, busy_r, tx_valid_r, io_req_r, io_we_r;
    logic [7:0]       tx_data_r, io_wdata_r;
    logic [IO_AW-1:0] io_addr_r;
    logic [ERR_W-1:0] err_cnt_r;
    logic [7:0]       mem_r [0:(2**MEM_AW)-1];

    logic        rx_fire_s, hdr_s, in_io_s, byte_done_s, last_s, mem_we_s;
    logic [31:0] cur_addr_s;
    logic [7:0]  cur_byte_s, mem_rdata_s;
    logic [2:0]  data_last_s;

    assign rx_fire_s   = rx_valid && rx_ready_r;
    assign hdr_s       = rx_fire_s && rx_data[7];
    assign cur_addr_s  = addr_r + {30'd0, idx_r};
    assign in_io_s     = (cur_addr_s[31:IO_AW] == IO_BASE[31:IO_AW]);
    assign cur_byte_s  = data_r[{idx_r, 3'b000} +: 8];
    assign mem_rdata_s = mem_r[cur_addr_s[MEM_AW-1:0]];
    assign data_last_s = {1'b0, len_r} + 3'd1;
    assign last_s      = (idx_r == len_r);
    assign byte_done_s = in_io_s ? (io_req_r && io_ack) : 1'b1;
    assign mem_we_s    = (state_r == S_WCOMMIT) && !in_io_s;

    assign rx_ready = rx_ready_r;
    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign io_req   = io_req_r;
    assign io_we    = io_we_r;
    assign io_addr  = io_addr_r;
    assign io_wdata = io_wdata_r;
    assign busy     = busy_r;
    assign err_cnt  = err_cnt_r;

    // Next-state decode; a header in ADDR/WDATA restarts the frame.
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (hdr_s) state_n = S_ADDR;
                else       state_n = S_IDLE;
            end
            S_ADDR: begin
                if (hdr_s)                               state_n = S_ADDR;
                else if (rx_fire_s && cnt_r == 3'd4)     state_n = is_read_r ? S_RFETCH : S_WDATA;
                else                                     state_n = S_ADDR;
            end
            S_WDATA: begin
                if (hdr_s)                                   state_n = S_ADDR;
                else if (rx_fire_s && cnt_r == data_last_s)  state_n = S_WCOMMIT;
                else                                         state_n = S_WDATA;
            end
            S_WCOMMIT: begin
                if (byte_done_s && last_s) state_n = S_IDLE;
                else                       state_n = S_WCOMMIT;
            end
            S_RFETCH: begin
                if (byte_done_s) state_n = S_RSEND;
                else             state_n = S_RFETCH;
            end
            S_RSEND: begin
                if (tx_valid_r && tx_ready) state_n = last_s ? S_IDLE : S_RFETCH;
                else                        state_n = S_RSEND;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register with registered busy/rx_ready derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b1;
        end else begin
            state_r    <= state_n;
            busy_r     <= (state_n != S_IDLE);
            rx_ready_r <= (state_n == S_IDLE) || (state_n == S_ADDR) || (state_n == S_WDATA);
        end
    end

    // Frame capture, commit/fetch sequencing, tx and MMIO handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_read_r  <= 1'b0;
            len_r      <= 2'd0;
            cnt_r      <= 3'd0;
            idx_r      <= 2'd0;
            addr_r     <= 32'd0;
            data_r     <= 32'd0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'd0;
            io_req_r   <= 1'b0;
            io_we_r    <= 1'b0;
            io_addr_r  <= {IO_AW{1'b0}};
            io_wdata_r <= 8'd0;
            err_cnt_r  <= {ERR_W{1'b0}};
        end else if (hdr_s) begin
            is_read_r <= rx_data[6];
            len_r     <= rx_data[1:0];
            cnt_r     <= 3'd0;
            idx_r     <= 2'd0;
            if (state_r != S_IDLE) err_cnt_r <= sat_inc(err_cnt_r);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (rx_fire_s) err_cnt_r <= sat_inc(err_cnt_r);
                end
                S_ADDR: begin
                    if (rx_fire_s && cnt_r == 3'd4) begin
                        addr_r[7]  <= rx_data[0];
                        addr_r[15] <= rx_data[1];
                        addr_r[23] <= rx_data[2];
                        addr_r[31] <= rx_data[3];
                        cnt_r      <= 3'd0;
                    end else if (rx_fire_s) begin
                        addr_r[{cnt_r[1:0], 3'b000} +: 7] <= rx_data[6:0];
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_fire_s && cnt_r == data_last_s) begin
                        data_r[7]  <= rx_data[0];
                        data_r[15] <= rx_data[1];
                        data_r[23] <= rx_data[2];
                        data_r[31] <= rx_data[3];
                        cnt_r      <= 3'd0;
                    end else if (rx_fire_s) begin
                        data_r[{cnt_r[1:0], 3'b000} +: 7] <= rx_data[6:0];
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                S_WCOMMIT: begin
                    if (!in_io_s) begin
                        idx_r <= idx_r + 2'd1;
                    end else if (!io_req_r) begin
                        io_req_r   <= 1'b1;
                        io_we_r    <= 1'b1;
                        io_addr_r  <= cur_addr_s[IO_AW-1:0];
                        io_wdata_r <= cur_byte_s;
                    end else if (io_ack) begin
                        io_req_r <= 1'b0;
                        idx_r    <= idx_r + 2'd1;
                    end
                end
                S_RFETCH: begin
                    if (!in_io_s) begin
                        tx_data_r <= mem_rdata_s;
                    end else if (!io_req_r) begin
                        io_req_r  <= 1'b1;
                        io_we_r   <= 1'b0;
                        io_addr_r <= cur_addr_s[IO_AW-1:0];
                    end else if (io_ack) begin
                        io_req_r   <= 1'b0;
                        tx_data_r  <= io_rdata;
                        tx_valid_r <= 1'b1;
                    end
                end
                S_RSEND: begin
                    // RAM bytes arrive with tx_valid low; I/O bytes already raised it on io_ack.
                    if (!tx_valid_r) begin
                        tx_valid_r <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid_r <= 1'b0;
                        idx_r      <= idx_r + 2'd1;
                    end
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) mem_r[cur_addr_s[MEM_AW-1:0]] <= cur_byte_s;
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Randomized self-checking bench for uart_mem_bridge against a byte-level memory/MMIO model.
module tb_uart_mem_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic [7:0] rx_data, tx_data;
    logic       io_req, io_we, io_ack, busy;
    logic [3:0] io_addr;
    logic [7:0] io_wdata, io_rdata;
    logic [7:0] err_cnt;

    uart_mem_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_ram [0:4095];
    logic [7:0]  ref_io  [0:15];
    logic [7:0]  io_dev  [0:15];
    logic [12:0] io_log [$];
    logic [12:0] io_exp [$];
    int          io_delay = 0;
    int          err_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= 32'h100) && (a < 32'h110);
    endfunction

    function automatic logic [7:0] expect_byte(input logic [31:0] a);
        if (in_win(a)) return ref_io[4'(a - 32'h100)];
        else return ref_ram[a[11:0]];
    endfunction

    // MMIO peripheral: acks each request after io_delay cycles.
    initial begin
        io_ack = 1'b0;
        io_rdata = 8'd0;
        forever begin
            @(negedge clk);
            if (io_req) begin
                repeat (io_delay) @(negedge clk);
                if (io_req) begin
                    if (io_we) begin
                        io_dev[io_addr] = io_wdata;
                        io_log.push_back({io_we, io_addr, io_wdata});
                    end else begin
                        io_rdata = io_dev[io_addr];
                    end
                    io_ack = 1'b1;
                    @(negedge clk);
                    io_ack = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_lanes(input logic [31:0] d, input int len);
        for (int i = 0; i < len; i++) send_byte({1'b0, d[8*i +: 7]});
        send_byte({4'b0000, d[31], d[23], d[15], d[7]});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle", 32'(busy), 32'd0);
    endtask

    task automatic recv_check(input int hold, input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) check_eq("tx_valid_timeout", 32'(tx_valid), 32'd1);
        for (int k = 0; k < hold; k++) begin
            check_eq("bp_data", 32'(tx_data), 32'(exp));
            check_eq("bp_rx_ready", 32'(rx_ready), 32'd0);
            @(negedge clk);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        check_eq(tag, 32'(tx_data), 32'(exp));
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int len, input bit timed);
        logic [31:0] ai;
        logic [7:0]  bt;
        send_byte({2'b10, 4'($urandom), 2'(len - 1)});
        send_lanes(a, 4);
        send_lanes(d, len);
        for (int i = 0; i < len; i++) begin
            ai = a + 32'(i);
            bt = d[8*i +: 8];
            if (in_win(ai)) begin
                ref_io[4'(ai - 32'h100)] = bt;
                io_exp.push_back({1'b1, 4'(ai - 32'h100), bt});
            end else begin
                ref_ram[ai[11:0]] = bt;
            end
        end
        if (timed) begin
            repeat (len) @(negedge clk);
            check_eq("wr_busy_before_end", 32'(busy), 32'd1);
            @(negedge clk);
            check_eq("wr_busy_after_end", 32'(busy), 32'd0);
        end
        wait_idle();
        check_eq("io_wr_count", 32'(io_log.size()), 32'(io_exp.size()));
        while (io_exp.size() > 0) begin
            if (io_log.size() > 0) check_eq("io_wr", 32'(io_log.pop_front()), 32'(io_exp.pop_front()));
            else void'(io_exp.pop_front());
        end
        io_log.delete();
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input int hold, input bit timed);
        send_byte({2'b11, 4'($urandom), 2'(len - 1)});
        send_lanes(a, 4);
        if (timed) begin
            @(negedge clk);
            @(negedge clk);
            check_eq("rd_valid_early", 32'(tx_valid), 32'd0);
            @(negedge clk);
            check_eq("rd_valid_on_time", 32'(tx_valid), 32'd1);
        end
        for (int i = 0; i < len; i++)
            recv_check((i == 0) ? hold : 0, expect_byte(a + 32'(i)), "rd_data");
        wait_idle();
    endtask

    initial begin
        int          len, n;
        logic [31:0] a, d;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            io_dev[i] = 8'(8'hA0 + i);
            ref_io[i] = 8'(8'hA0 + i);
        end

        repeat (3) @(negedge clk);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_io_req", 32'(io_req), 32'd0);
        check_eq("rst_io_we", 32'(io_we), 32'd0);
        check_eq("rst_io_addr", 32'(io_addr), 32'd0);
        check_eq("rst_io_wdata", 32'(io_wdata), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
        rst_n = 1'b1;

        // Basic 4-byte write/read with latency checks.
        do_write(32'h0000_0010, 32'h1234_5678, 4, 1'b1);
        do_read(32'h0000_0010, 4, 0, 1'b1);

        // MSB reconstruction and RAM aliasing.
        do_write(32'h8000_1FFF, 32'h0000_00FF, 1, 1'b0);
        do_read(32'h0000_0FFF, 1, 0, 1'b0);

        // MMIO write must leave the aliased RAM bytes alone.
        do_write(32'h0000_1104, 32'h0000_2211, 2, 1'b0);
        io_delay = 3;
        do_write(32'h0000_0104, 32'h0000_CDAB, 2, 1'b0);
        do_read(32'h0000_1104, 2, 0, 1'b0);
        do_read(32'h0000_0104, 2, 0, 1'b0);
        io_delay = 0;

        // Resync from ADDR and from WDATA, then a stray byte in IDLE.
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'h00);
        err_exp++;
        do_read(32'h0000_0010, 1, 0, 1'b0);
        check_eq("err_after_addr_resync", 32'(err_cnt), 32'(err_exp));
        send_byte(8'h81);
        send_lanes(32'h0000_0010, 4);
        send_byte(8'h55);
        err_exp++;
        do_read(32'h0000_0010, 4, 0, 1'b0);
        check_eq("err_after_data_resync", 32'(err_cnt), 32'(err_exp));
        send_byte(8'h05);
        err_exp++;
        @(negedge clk);
        check_eq("err_after_stray", 32'(err_cnt), 32'(err_exp));

        // tx backpressure on the first byte of a 4-byte read.
        do_read(32'h0000_0010, 4, 10, 1'b0);

        // Address wraparound modulo 2**32.
        do_write(32'hFFFF_FFFE, 32'hA1B2_C3D4, 4, 1'b0);
        do_read(32'hFFFF_FFFE, 4, 0, 1'b0);

        // Randomized frames across RAM, the MMIO window and its edges.
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       a = $urandom;
                1:       a = 32'h0000_00FC + 32'($urandom_range(0, 20));
                default: a = 32'($urandom_range(0, 4095));
            endcase
            d = $urandom;
            io_delay = $urandom_range(0, 3);
            do_write(a, d, len, 1'b0);
            do_read(a, len, 0, 1'b0);
        end
        check_eq("err_after_random", 32'(err_cnt), 32'(err_exp));

        // Reset while a read byte is pending on tx.
        io_delay = 0;
        send_byte(8'hC3);
        send_lanes(32'h0000_0010, 4);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("pre_reset_tx_valid", 32'(tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        err_exp = 0;
        check_eq("reset_err_cnt", 32'(err_cnt), 32'd0);
        do_read(32'h0000_0010, 4, 0, 1'b0);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) send_byte(8'h05);
        @(negedge clk);
        check_eq("err_saturate", 32'(err_cnt), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
